// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 8N1 UART receiver, LSB first, idle-high line.
//
// The line is oversampled at CLKS_PER_BIT = CLOCK_FREQ / BOUD_RATE clocks per
// bit. A falling edge on the synchronized line starts a frame. The start bit
// is confirmed at its centre, and that phase offset places every later sample
// at the centre of its bit.
//
// Ports
//   i_master_clk      in   1  single clock, rising edge
//   i_reset_n         in   1  asynchronous, active-low reset
//   i_uart_rx         in   1  asynchronous serial line
//   o_rx_data         out  8  last correctly framed byte (held until replaced)
//   o_rx_data_valid   out  1  one-cycle pulse, o_rx_data is new in that cycle
//   o_rx_frame_error  out  1  one-cycle pulse, stop bit sampled low
//   o_rx_busy         out  1  high whenever the receiver is not idle
//
// Build option
//   UART_RX_MAJORITY_EN : when defined, each bit decision is the 2-of-3
//   majority of three consecutive synchronized samples around the sample
//   point. The decision lands one clock later than in the default build.
//   When undefined, a single sample is used and no voting logic exists.
//
// States
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | timing to the start-bit centre to reject glitches
//   DATA  | sampling 8 data bits, one per bit period
//   STOP  | sampling the stop bit, then reporting the byte or a frame error
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BOUD_RATE  = 115200
) (
    input  logic       i_master_clk,
    input  logic       i_reset_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_data_valid,
    output logic       o_rx_frame_error,
    output logic       o_rx_busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BOUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the centre, so the start decision
    // moves one count later. Everything after it inherits the shift, which
    // keeps the vote window centred on every later bit as well.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CLKS_PER_BIT / 2 + 1);
`else
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CLKS_PER_BIT / 2);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic sync_ff1;
    logic sync;
    logic prev_sync;
    logic sample;

    // The synchronizer flops come out of reset holding 1. These flags stop
    // the first real low value after reset from looking like a falling edge.
    // The receiver only arms once a genuine high has passed through.
    logic [1:0] line_qual;
    logic       line_armed;

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_ff1   <= 1'b1;
            sync       <= 1'b1;
            prev_sync  <= 1'b1;
            line_qual  <= 2'b00;
            line_armed <= 1'b0;
        end else begin
            sync_ff1  <= i_uart_rx;
            sync      <= sync_ff1;
            prev_sync <= sync;
            line_qual <= {line_qual[0], 1'b1};
            if (line_qual[1] && sync) begin
                line_armed <= 1'b1;
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic sync_d1;
    logic sync_d2;

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_d1 <= 1'b1;
            sync_d2 <= 1'b1;
        end else begin
            sync_d1 <= sync;
            sync_d2 <= sync_d1;
        end
    end

    assign sample = (sync & sync_d1) | (sync & sync_d2) | (sync_d1 & sync_d2);
`else
    assign sample = sync;
`endif

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bit_idx          <= 3'd0;
            shift            <= 8'h00;
            o_rx_data        <= 8'h00;
            o_rx_data_valid  <= 1'b0;
            o_rx_frame_error <= 1'b0;
            o_rx_busy        <= 1'b0;
        end else begin
            o_rx_data_valid  <= 1'b0;
            o_rx_frame_error <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    if (line_armed && prev_sync && !sync) begin
                        state     <= START;
                        o_rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_START) begin
                        cnt <= '0;
                        if (!sample) begin
                            state <= DATA;
                        end else begin
                            // Line was high again at mid-start: a glitch.
                            state     <= IDLE;
                            o_rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shift <= {sample, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        o_rx_busy <= 1'b0;
                        if (sample) begin
                            o_rx_data       <= shift;
                            o_rx_data_valid <= 1'b1;
                        end else begin
                            o_rx_frame_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    o_rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
